part_o_split: RTL and testbench
===============================

Name: part_o_split

Overview:
- 1-to-3 stream distributor; the reverse direction of the part_i 3-to-1 merger.
- Accepts a single 8-bit valid/ready stream and deals words round-robin into three per-lane show-ahead FIFOs.
- Each lane's reader pulls words with its own read-enable.
- Used on the fan-out side of the 9x1 datapath and by co-sim benches to regenerate per-part input streams.

Parameters:
- DW, 8, data width of the stream and of each lane.
- DEPTH, 4, entries per lane FIFO; power of 2, at least 2.

Ports:
- i_clk  in  1  single clock; all logic is rising-edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_flush  in  1  synchronous clear of all lanes and the round-robin pointer.
- i_valid  in  1  input word present.
- i_data  in  DW  input word.
- o_ready  out  1  block can accept i_data this cycle.
- i_ren  in  3  per-lane read enable; bit k belongs to lane k.
- o_valid  out  3  lane k head word is valid.
- o_data0  out  DW  lane 0 head word.
- o_data1  out  DW  lane 1 head word.
- o_data2  out  DW  lane 2 head word.
- o_level0, o_level1, o_level2  out  $clog2(DEPTH+1)  current occupancy of each lane.
- o_err  out  3  sticky underrun flag per lane.

Behaviour:
- Reset (i_rst=1, asynchronous, takes effect immediately without a clock):
  - All lanes empty; rr_ptr=0.
  - o_valid=0, o_data0..2=0, o_level*=0, o_err=0.
  - o_ready=1 once i_rst deasserts.
- Round-robin pointer rr_ptr is 2 bits and cycles 0->1->2->0. It advances only on an accepted word.
- o_ready = !i_flush && !full[rr_ptr]. It is a function of registered state plus i_flush only, with no combinational path from i_valid or i_ren.
- Accept condition is i_valid && o_ready. On accept, i_data is pushed into lane rr_ptr and rr_ptr advances.
- Strict order: a full target lane stalls the input. The block never skips to another lane.
- Show-ahead lane output:
  - o_valid[k] = level_k != 0.
  - o_dataK = head word when valid, 0 when empty.
  - A word accepted at edge N is visible on o_valid/o_dataK after edge N (same cycle as the new level). Latency is 1 cycle.
- Pop: i_ren[k] && o_valid[k] removes the head at the edge, and the next word is presented in the following cycle.
- i_ren[k] while lane k is empty: no state change, and o_err[k] is set to 1. o_err[k] stays set until reset or flush.
- Simultaneous push and pop on the same lane:
  - Lane not full: level unchanged, FIFO order preserved.
  - Lane full: push is blocked because o_ready=0. There is no pass-through or bypass.
- Push into an empty lane with i_ren[k] asserted in the same cycle: the pop is an underrun and sets o_err[k]. The push still completes.
- Lane storage uses read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. Level is held as a separate counter, range 0..DEPTH.
- i_flush=1 (synchronous, highest priority after reset):
  - At the edge: all levels 0, pointers 0, rr_ptr=0, o_err=0.
  - The same-cycle input word is not accepted (o_ready=0).
  - Same-cycle i_ren is ignored, and no o_err is set.
- Overflow is impossible by construction. The bench asserts level_k <= DEPTH.

Decomposition:
- Package part_split_pkg holds:
  - NLANE=3.
  - lane_idx_t (logic [1:0]).
  - Function next_lane(lane_idx_t), which returns 0 after 2.
  - Default DW/DEPTH constants.
- Sub-module split_lane_fifo, instantiated 3 times:
  - Ports: i_clk, i_rst, i_flush, i_push, i_data, i_pop, o_valid, o_data, o_full, o_level, o_err.
- The top holds rr_ptr, o_ready and the push/pop steering.

Test Plan:
- Reset, push 0x10..0x15 back-to-back with no reads -> lane0 holds 10,13; lane1 holds 11,14; lane2 holds 12,15; levels 2/2/2; o_dataK shows 10/11/12; o_ready=1.
- DEPTH=4, push 0x00..0x0B -> all levels 4.
  - Next word 0x0C sees o_ready=0 with rr_ptr=0.
  - Pulse i_ren[0] for one cycle -> o_data0 changes 00->03, o_ready=1 on the next cycle, 0x0C lands in lane0 with level0 back to 4.
- Lane1 empty, i_ren[1]=1 for one cycle -> o_err=3'b010 stays sticky; levels unchanged; further pushes are unaffected.
- Lane0 level 2 (0x20,0x23): push 0x26 to lane0 and pop lane0 in the same cycle -> level0 stays 2; subsequent pops yield 0x23 then 0x26.
- Mid-stream i_flush with i_valid=1, i_data=0x55 -> that cycle o_ready=0; next cycle all levels 0, o_err=0, o_valid=0; the next accepted word 0x56 goes to lane0.
- Assert i_rst between clock edges with all lanes partially full -> o_valid, o_level* and o_err drop to 0 before the next edge; after deassert, the first push goes to lane0.

Source files
------------

// File: rtl/part_split_pkg.sv
// Shared definitions for the part_o_split 1-to-3 stream distributor.
//   NLANE      : number of output lanes
//   lane_idx_t : lane selector / round-robin pointer type
//   next_lane  : round-robin successor (0 -> 1 -> 2 -> 0)
//   DW_DEF, DEPTH_DEF : default data width and per-lane FIFO depth
package part_split_pkg;

  localparam int unsigned NLANE     = 3;
  localparam int unsigned DW_DEF    = 8;
  localparam int unsigned DEPTH_DEF = 4;

  typedef logic [1:0] lane_idx_t;

  function automatic lane_idx_t next_lane(input lane_idx_t cur);
    return (cur >= lane_idx_t'(NLANE - 1)) ? '0 : lane_idx_t'(cur + 2'd1);
  endfunction

endpackage

// File: rtl/part_o_split_lane.sv
// split_lane_fifo: one show-ahead lane FIFO of the part_o_split distributor.
// Ports:
//   i_clk, i_rst   : rising-edge clock, asynchronous active-high reset
//   i_flush        : synchronous clear (pointers, level, error flag)
//   i_push, i_data : write a word (caller guarantees the lane is not full)
//   i_pop          : remove the head word; popping an empty lane sets o_err
//   o_valid/o_data : head word, o_data forced to 0 while empty
//   o_full/o_level : occupancy, level counts 0..DEPTH
//   o_err          : sticky underrun flag
module split_lane_fifo
  import part_split_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned LW   = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic          o_full,
  output logic [LW-1:0] o_level,
  output logic          o_err
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          err;
  logic          empty;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_push = i_push && !full;
  // Pop is evaluated against the pre-edge level, so a pop on an empty lane
  // is an underrun even when a push lands in the same cycle.
  assign do_pop  = i_pop && !empty;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      err    <= 1'b0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      err    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (i_pop && empty) err <= 1'b1;
    end
  end

  // Storage needs no reset: contents are only visible while level != 0.
  always_ff @(posedge i_clk) begin
    if (do_push && !i_flush) mem[wr_ptr] <= i_data;
  end

  assign o_valid = !empty;
  assign o_data  = empty ? '0 : mem[rd_ptr];
  assign o_full  = full;
  assign o_level = level;
  assign o_err   = err;

endmodule

// File: rtl/part_o_split.sv
// part_o_split: 1-to-3 stream distributor. Words accepted on the single
// valid/ready input are dealt round-robin (lane 0, 1, 2, 0, ...) into three
// show-ahead lane FIFOs; a full target lane stalls the input (no skipping).
// Ports:
//   i_clk, i_rst        : rising-edge clock, asynchronous active-high reset
//   i_flush             : synchronous clear of all lanes and the pointer
//   i_valid/i_data      : input stream, o_ready is the accept qualifier
//   i_ren[k]            : lane k read enable
//   o_valid[k], o_dataK : lane k head word (0 when empty)
//   o_levelK            : lane k occupancy
//   o_err[k]            : lane k sticky underrun flag
module part_o_split
  import part_split_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned LW   = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_flush,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  output logic          o_ready,
  input  logic [2:0]    i_ren,
  output logic [2:0]    o_valid,
  output logic [DW-1:0] o_data0,
  output logic [DW-1:0] o_data1,
  output logic [DW-1:0] o_data2,
  output logic [LW-1:0] o_level0,
  output logic [LW-1:0] o_level1,
  output logic [LW-1:0] o_level2,
  output logic [2:0]    o_err
);

  lane_idx_t       rr_ptr;
  logic [2:0]      full;
  logic [2:0]      push;
  logic            target_full;
  logic            accept;
  logic [DW-1:0]   lane_data  [NLANE];
  logic [LW-1:0]   lane_level [NLANE];

  // Explicit mux keeps the unused pointer code 3 from indexing past the vector.
  always_comb begin
    target_full = full[0];
    case (rr_ptr)
      2'd1:    target_full = full[1];
      2'd2:    target_full = full[2];
      default: target_full = full[0];
    endcase
  end

  assign o_ready = !i_flush && !target_full;
  assign accept  = i_valid && o_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        rr_ptr <= '0;
    else if (i_flush) rr_ptr <= '0;
    else if (accept)  rr_ptr <= next_lane(rr_ptr);
  end

  for (genvar k = 0; k < NLANE; k++) begin : g_lane
    assign push[k] = accept && (rr_ptr == lane_idx_t'(k));

    split_lane_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_lane (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_flush (i_flush),
      .i_push  (push[k]),
      .i_data  (i_data),
      .i_pop   (i_ren[k]),
      .o_valid (o_valid[k]),
      .o_data  (lane_data[k]),
      .o_full  (full[k]),
      .o_level (lane_level[k]),
      .o_err   (o_err[k])
    );
  end

  assign o_data0  = lane_data[0];
  assign o_data1  = lane_data[1];
  assign o_data2  = lane_data[2];
  assign o_level0 = lane_level[0];
  assign o_level1 = lane_level[1];
  assign o_level2 = lane_level[2];

endmodule

// File: tb/tb_part_o_split.sv
// Self-checking bench for part_o_split: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_part_o_split;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(DEPTH + 1);

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_flush;
  logic          i_valid;
  logic [DW-1:0] i_data;
  logic          o_ready;
  logic [2:0]    i_ren;
  logic [2:0]    o_valid;
  logic [DW-1:0] o_data0, o_data1, o_data2;
  logic [LW-1:0] o_level0, o_level1, o_level2;
  logic [2:0]    o_err;

  part_o_split #(.DW(DW), .DEPTH(DEPTH)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_flush  (i_flush),
    .i_valid  (i_valid),
    .i_data   (i_data),
    .o_ready  (o_ready),
    .i_ren    (i_ren),
    .o_valid  (o_valid),
    .o_data0  (o_data0),
    .o_data1  (o_data1),
    .o_data2  (o_data2),
    .o_level0 (o_level0),
    .o_level1 (o_level1),
    .o_level2 (o_level2),
    .o_err    (o_err)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: one queue per lane, a lane counter and sticky flags.
  logic [DW-1:0] q [3][$];
  int            rr;
  logic [2:0]    m_err;
  int            n_checks = 0;
  int            n_fail   = 0;

  logic [DW-1:0] dut_data  [3];
  logic [LW-1:0] dut_level [3];
  assign dut_data[0]  = o_data0;
  assign dut_data[1]  = o_data1;
  assign dut_data[2]  = o_data2;
  assign dut_level[0] = o_level0;
  assign dut_level[1] = o_level1;
  assign dut_level[2] = o_level2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 3; k++) q[k].delete();
    rr    = 0;
    m_err = '0;
  endtask

  function automatic bit model_ready(input bit flush);
    return !flush && (q[rr].size() < DEPTH);
  endfunction

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_valid%0d", tag, k), 32'(o_valid[k]), 32'(q[k].size() != 0));
      check($sformatf("%s_data%0d", tag, k), 32'(dut_data[k]),
            (q[k].size() != 0) ? 32'(q[k][0]) : 32'd0);
      check($sformatf("%s_level%0d", tag, k), 32'(dut_level[k]), 32'(q[k].size()));
      n_checks++;
      assert (dut_level[k] <= LW'(DEPTH)) else begin
        n_fail++;
        $error("FAIL %s_ovf%0d observed=%0d expected<=%0d", tag, k, dut_level[k], DEPTH);
      end
    end
    check({tag, "_err"}, 32'(o_err), 32'(m_err));
  endtask

  // One clock cycle: entered just after a rising edge, returns 1 time unit
  // after the next rising edge with the model advanced and outputs checked.
  task automatic cycle(input string tag, input bit valid, input logic [DW-1:0] data,
                       input logic [2:0] ren, input bit flush);
    bit rdy;
    i_valid = valid;
    i_data  = data;
    i_ren   = ren;
    i_flush = flush;
    #1;
    rdy = model_ready(flush);
    check({tag, "_ready"}, 32'(o_ready), 32'(rdy));
    @(posedge i_clk);
    if (flush) begin
      model_clear();
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (ren[k]) begin
          if (q[k].size() != 0) void'(q[k].pop_front());
          else m_err[k] = 1'b1;
        end
      end
      if (valid && rdy) begin
        q[rr].push_back(data);
        rr = (rr + 1) % 3;
      end
    end
    #1;
    i_valid = 1'b0;
    i_ren   = '0;
    i_flush = 1'b0;
    check_all(tag);
  endtask

  initial begin
    i_rst   = 1'b1;
    i_flush = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    i_ren   = '0;
    model_clear();
    #3;
    check_all("rst");
    #9;
    i_rst = 1'b0;
    #1;
    check("rst_ready", 32'(o_ready), 32'd1);
    @(posedge i_clk); #1;

    // Six words, no reads: 10/13 in lane0, 11/14 lane1, 12/15 lane2.
    for (int i = 0; i < 6; i++) cycle("fill6", 1'b1, DW'(8'h10 + i), 3'b000, 1'b0);
    check("fill6_d0", 32'(o_data0), 32'h10);
    check("fill6_d1", 32'(o_data1), 32'h11);
    check("fill6_d2", 32'(o_data2), 32'h12);
    check("fill6_l1", 32'(o_level1), 32'd2);

    // Fill every lane, then stall on the full lane0.
    cycle("fl1", 1'b0, '0, 3'b000, 1'b1);
    for (int i = 0; i < 12; i++) cycle("full", 1'b1, DW'(i), 3'b000, 1'b0);
    check("full_l2", 32'(o_level2), 32'd4);
    cycle("stall", 1'b1, 8'h0C, 3'b000, 1'b0);
    cycle("pop0", 1'b1, 8'h0C, 3'b001, 1'b0);
    check("pop0_d0", 32'(o_data0), 32'h03);
    cycle("land0c", 1'b1, 8'h0C, 3'b000, 1'b0);
    check("land0c_l0", 32'(o_level0), 32'd4);

    // Underrun on lane1 is sticky and does not disturb traffic.
    cycle("fl2", 1'b0, '0, 3'b000, 1'b1);
    cycle("under", 1'b0, '0, 3'b010, 1'b0);
    check("under_err", 32'(o_err), 32'b010);
    for (int i = 0; i < 4; i++) cycle("after_under", 1'b1, DW'(8'h40 + i), 3'b000, 1'b0);
    check("after_under_err", 32'(o_err), 32'b010);

    // Push into an empty lane with a same-cycle read: underrun, push lands.
    cycle("fl3", 1'b0, '0, 3'b000, 1'b1);
    cycle("pushpop_empty", 1'b1, 8'h77, 3'b001, 1'b0);
    check("pushpop_empty_err", 32'(o_err), 32'b001);
    check("pushpop_empty_d0", 32'(o_data0), 32'h77);

    // Simultaneous push/pop on lane0 at level 2 keeps level and order.
    cycle("fl4", 1'b0, '0, 3'b000, 1'b1);
    for (int i = 0; i < 6; i++) cycle("pp_fill", 1'b1, DW'(8'h20 + i), 3'b000, 1'b0);
    cycle("pp", 1'b1, 8'h26, 3'b001, 1'b0);
    check("pp_l0", 32'(o_level0), 32'd2);
    check("pp_d0a", 32'(o_data0), 32'h23);
    cycle("pp_pop1", 1'b0, '0, 3'b001, 1'b0);
    check("pp_d0b", 32'(o_data0), 32'h26);
    cycle("pp_pop2", 1'b0, '0, 3'b001, 1'b0);

    // Mid-stream flush with a word offered: not accepted, pointer restarts.
    for (int i = 0; i < 4; i++) cycle("pre_flush", 1'b1, DW'(8'h50 + i), 3'b000, 1'b0);
    cycle("pre_flush_under", 1'b0, '0, 3'b100, 1'b0);
    cycle("flush55", 1'b1, 8'h55, 3'b111, 1'b1);
    check("flush55_valid", 32'(o_valid), 32'd0);
    cycle("after_flush", 1'b1, 8'h56, 3'b000, 1'b0);
    check("after_flush_d0", 32'(o_data0), 32'h56);

    // Asynchronous reset between edges with partially full lanes.
    for (int i = 0; i < 4; i++) cycle("pre_rst", 1'b1, DW'(8'h60 + i), 3'b000, 1'b0);
    cycle("pre_rst_under", 1'b0, '0, 3'b100, 1'b0);
    cycle("pre_rst_under2", 1'b0, '0, 3'b100, 1'b0);
    #2;
    i_rst = 1'b1;
    #1;
    model_clear();
    check_all("arst");
    @(posedge i_clk);
    #3;
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    cycle("post_rst", 1'b1, 8'h99, 3'b000, 1'b0);
    check("post_rst_d0", 32'(o_data0), 32'h99);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle("rand", ($urandom_range(0, 3) != 0), DW'($urandom),
            3'($urandom & $urandom), ($urandom_range(0, 59) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
